// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock/tick divider with clean start/stop gating.
// Divisor changes are applied only at half-period boundaries.
module clk_div_prog #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 749
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIV_LD,
    input  logic [CNT_W-1:0] DIV_IN,
    output logic             CLKOUT,
    output logic             RISE,
    output logic             FALL,
    output logic             ACTIVE,
    output logic [CNT_W-1:0] DIV_ACT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend_vld;
    logic             r_clkout;
    logic             r_rise;
    logic             r_fall;
    logic             r_active;

    logic [CNT_W-1:0] w_div_commit;
    logic             w_term;

    // A load in the same cycle as a commit point wins over the older pending value.
    assign w_div_commit = DIV_LD ? DIV_IN : (r_pend_vld ? r_div_pend : r_div_act);
    assign w_term       = (r_cnt == r_div_act);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div_act  <= CNT_W'(DEFAULT_DIV);
            r_div_pend <= '0;
            r_pend_vld <= 1'b0;
            r_clkout   <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt    <= '0;
                    r_clkout <= 1'b0;
                    if (DIV_LD) begin
                        r_div_act <= DIV_IN;
                    end
                    if (EN) begin
                        r_state  <= RUN;
                        r_active <= 1'b1;
                        r_clkout <= 1'b1;
                        r_rise   <= 1'b1;
                    end
                end
                default: begin
                    if (!r_clkout && !EN) begin
                        r_state    <= IDLE;
                        r_active   <= 1'b0;
                        r_cnt      <= '0;
                        r_div_act  <= w_div_commit;
                        r_pend_vld <= 1'b0;
                    end else if (w_term) begin
                        // Leaving a high phase with EN low ends in IDLE after its FALL.
                        r_clkout   <= ~r_clkout;
                        r_rise     <= ~r_clkout;
                        r_fall     <= r_clkout;
                        r_cnt      <= '0;
                        r_div_act  <= w_div_commit;
                        r_pend_vld <= 1'b0;
                        if (r_clkout && !EN) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_state  <= RUN;
                            r_active <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (DIV_LD) begin
                            r_div_pend <= DIV_IN;
                            r_pend_vld <= 1'b1;
                        end
                        r_state  <= (r_clkout && !EN) ? STOP : RUN;
                        r_active <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign CLKOUT  = r_clkout;
    assign RISE    = r_rise;
    assign FALL    = r_fall;
    assign ACTIVE  = r_active;
    assign DIV_ACT = r_div_act;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: expected RISE/FALL events are queued with their cycle
// stamps by the driver and checked by an independent monitor.
module tb_clk_div_prog;

    localparam int unsigned CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN = 1'b0;
    logic             DIV_LD = 1'b0;
    logic [CNT_W-1:0] DIV_IN = '0;
    logic             CLKOUT;
    logic             RISE;
    logic             FALL;
    logic             ACTIVE;
    logic [CNT_W-1:0] DIV_ACT;

    clk_div_prog #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(749)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .DIV_LD (DIV_LD),
        .DIV_IN (DIV_IN),
        .CLKOUT (CLKOUT),
        .RISE   (RISE),
        .FALL   (FALL),
        .ACTIVE (ACTIVE),
        .DIV_ACT(DIV_ACT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          rise;
        int unsigned cyc;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic exp_ev(input bit r, input int unsigned t);
        ev_t e;
        e.rise = r;
        e.cyc  = t;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic load_idle(input logic [CNT_W-1:0] v);
        DIV_LD = 1'b1;
        DIV_IN = v;
        @(negedge CLK);
        DIV_LD = 1'b0;
        chk("div_act_idle_load", 32'(DIV_ACT), 32'(v));
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (RISE && FALL) begin
            n_vec++;
            n_bad++;
            $display("FAIL rise_fall_both: both strobes high at cycle %0d", cyc);
        end else if (RISE || FALL) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: rise=%0d fall=%0d at cycle %0d, none expected",
                         RISE, FALL, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.rise !== RISE || e.cyc != cyc || CLKOUT !== RISE) begin
                    n_bad++;
                    $display("FAIL strobe_event: got rise=%0d clkout=%0d at cycle %0d, expected rise=%0d at cycle %0d",
                             RISE, CLKOUT, cyc, e.rise, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned c;

        // Reset state
        @(negedge CLK);
        chk("rst_clkout", 32'(CLKOUT), 0);
        chk("rst_active", 32'(ACTIVE), 0);
        chk("rst_rise", 32'(RISE), 0);
        chk("rst_fall", 32'(FALL), 0);
        chk("rst_div_act", 32'(DIV_ACT), 749);
        RST = 1'b0;
        @(negedge CLK);

        // Default divisor: 750 high / 750 low
        c = cyc;
        EN = 1'b1;
        for (int unsigned k = 0; k < 2; k++) begin
            exp_ev(1'b1, c + 1 + k * 1500);
            exp_ev(1'b0, c + 751 + k * 1500);
        end
        @(negedge CLK);
        chk("start_active", 32'(ACTIVE), 1);
        chk("start_clkout", 32'(CLKOUT), 1);
        wait_until(c + 750);
        chk("default_high_end", 32'(CLKOUT), 1);
        wait_until(c + 2260);
        EN = 1'b0;
        @(negedge CLK);
        chk("low_stop_active", 32'(ACTIVE), 0);
        chk("low_stop_clkout", 32'(CLKOUT), 0);
        chk("queue_after_default", exp_q.size(), 0);

        // Divisor 3 loaded in IDLE, 4 high / 4 low
        load_idle(16'd3);
        c = cyc;
        EN = 1'b1;
        exp_ev(1'b1, c + 1);
        exp_ev(1'b0, c + 5);
        exp_ev(1'b1, c + 9);
        exp_ev(1'b0, c + 13);
        wait_until(c + 14);
        EN = 1'b0;
        @(negedge CLK);
        chk("div3_stop_active", 32'(ACTIVE), 0);

        // Divisor 9 with mid-phase reloads, last-wins, and same-cycle load at terminal count
        load_idle(16'd9);
        c = cyc;
        EN = 1'b1;
        exp_ev(1'b1, c + 1);
        exp_ev(1'b0, c + 11);
        exp_ev(1'b1, c + 14);
        exp_ev(1'b0, c + 17);
        exp_ev(1'b1, c + 20);
        exp_ev(1'b0, c + 23);
        exp_ev(1'b1, c + 31);
        exp_ev(1'b0, c + 39);
        exp_ev(1'b1, c + 47);
        exp_ev(1'b0, c + 55);
        exp_ev(1'b1, c + 57);
        exp_ev(1'b0, c + 59);
        wait_until(c + 5);
        DIV_LD = 1'b1;
        DIV_IN = 16'd2;
        @(negedge CLK);
        DIV_LD = 1'b0;
        chk("pend_not_applied", 32'(DIV_ACT), 9);
        wait_until(c + 11);
        chk("div2_committed", 32'(DIV_ACT), 2);
        wait_until(c + 20);
        DIV_LD = 1'b1;
        DIV_IN = 16'd5;
        @(negedge CLK);
        DIV_IN = 16'd7;
        @(negedge CLK);
        DIV_LD = 1'b0;
        chk("pend7_not_applied", 32'(DIV_ACT), 2);
        wait_until(c + 23);
        chk("last_load_wins", 32'(DIV_ACT), 7);
        wait_until(c + 54);
        DIV_LD = 1'b1;
        DIV_IN = 16'd1;
        @(negedge CLK);
        DIV_LD = 1'b0;
        chk("load_at_terminal", 32'(DIV_ACT), 1);
        wait_until(c + 59);
        EN = 1'b0;
        @(negedge CLK);
        chk("div9_stop_active", 32'(ACTIVE), 0);

        // Stop requested during high phase: full-length high, one FALL
        load_idle(16'd9);
        c = cyc;
        EN = 1'b1;
        exp_ev(1'b1, c + 1);
        exp_ev(1'b0, c + 11);
        wait_until(c + 3);
        EN = 1'b0;
        wait_until(c + 10);
        chk("stop_high_clkout", 32'(CLKOUT), 1);
        chk("stop_high_active", 32'(ACTIVE), 1);
        @(negedge CLK);
        chk("stop_done_active", 32'(ACTIVE), 0);
        chk("stop_done_clkout", 32'(CLKOUT), 0);
        wait_until(c + 30);
        chk("queue_after_stop", exp_q.size(), 0);

        // Divisor 0: strobes alternate every cycle
        load_idle(16'd0);
        c = cyc;
        EN = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            exp_ev(1'b1, c + 1 + 2 * k);
            exp_ev(1'b0, c + 2 + 2 * k);
        end
        wait_until(c + 6);
        EN = 1'b0;
        @(negedge CLK);
        chk("div0_stop_active", 32'(ACTIVE), 0);

        // STOP then EN re-asserted: period undisturbed; pending divisor committed on IDLE entry
        load_idle(16'd3);
        c = cyc;
        EN = 1'b1;
        exp_ev(1'b1, c + 1);
        exp_ev(1'b0, c + 5);
        exp_ev(1'b1, c + 9);
        exp_ev(1'b0, c + 13);
        wait_until(c + 2);
        EN = 1'b0;
        @(negedge CLK);
        chk("stop_state_active", 32'(ACTIVE), 1);
        chk("stop_state_clkout", 32'(CLKOUT), 1);
        EN = 1'b1;
        wait_until(c + 13);
        DIV_LD = 1'b1;
        DIV_IN = 16'd5;
        @(negedge CLK);
        DIV_LD = 1'b0;
        EN = 1'b0;
        chk("pend_before_idle", 32'(DIV_ACT), 3);
        @(negedge CLK);
        chk("pend_on_idle", 32'(DIV_ACT), 5);
        chk("pend_idle_active", 32'(ACTIVE), 0);

        // Asynchronous reset mid-high-phase
        c = cyc;
        EN = 1'b1;
        exp_ev(1'b1, c + 1);
        wait_until(c + 3);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_clkout", 32'(CLKOUT), 0);
        chk("arst_active", 32'(ACTIVE), 0);
        chk("arst_rise", 32'(RISE), 0);
        chk("arst_fall", 32'(FALL), 0);
        @(negedge CLK);
        EN = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        chk("arst_div_act", 32'(DIV_ACT), 749);
        repeat (5) @(negedge CLK);
        chk("queue_final", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable, glitch-free clock/tick divider: generates a 50%-duty CLKOUT from CLK with a half-period of (DIV+1) CLK cycles, plus single-cycle RISE/FALL strobes in the CLK domain for logic that must not clock on CLKOUT. It supersedes fixed-ratio dividers feeding Pmod serial engines (SPI/joystick, display refresh), adds clean start/stop gating, and applies divisor changes only at half-period boundaries. One instance per required rate.

## Interface
- CNT_W, 16, width of divisor and internal counter
- DEFAULT_DIV, 749, divisor after reset (100 MHz -> 66.67 kHz)

- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-high
- EN  in  1  run request; level-sensitive
- DIV_LD  in  1  one-cycle strobe; captures DIV_IN
- DIV_IN  in  CNT_W  new divisor; half-period = DIV_IN+1 cycles
- CLKOUT  out  1  divided clock, registered
- RISE  out  1  high for the one cycle in which CLKOUT is 1 for the first cycle of a high phase
- FALL  out  1  high for the one cycle in which CLKOUT is 0 for the first cycle of a low phase
- ACTIVE  out  1  high whenever state != IDLE
- DIV_ACT  out  CNT_W  divisor currently in effect

## Operation
- Registers: state {IDLE, RUN, STOP}, cnt[CNT_W], div_act, div_pend, pend_vld.
- Reset (async): state=IDLE, CLKOUT=0, RISE=0, FALL=0, ACTIVE=0, cnt=0, div_act=DEFAULT_DIV, pend_vld=0.
- IDLE: CLKOUT=0, cnt=0. DIV_LD writes div_act directly. EN=1 -> CLKOUT<=1, RISE<=1, cnt<=0, state RUN.
- RUN: cnt increments; at cnt==div_act: CLKOUT toggles, cnt<=0, strobe RISE or FALL matching the new level; div_act<=div_pend if pend_vld, pend_vld<=0.
- DIV_LD in RUN/STOP: div_pend<=DIV_IN, pend_vld<=1; later load before boundary overwrites (last wins). DIV_LD in the same cycle as terminal count: DIV_IN goes straight to div_act at that boundary.
- EN=0 in RUN with CLKOUT=0: state IDLE next edge, cnt<=0, no FALL (already low). Pending divisor committed to div_act on entry to IDLE.
- EN=0 in RUN with CLKOUT=1: state STOP; high phase runs to full length; at terminal count CLKOUT<=0, FALL<=1, state IDLE. No runt pulse.
- STOP with EN=1 again: back to RUN without disturbing cnt/CLKOUT.
- Width: cnt and compare are CNT_W bits, unsigned; DIV_IN=0 legal (CLKOUT=CLK/2, RISE/FALL alternate every cycle). DIV_IN=2^CNT_W-1 legal; cnt never wraps past div_act.

## Timing
- All outputs registered; no combinational path input->output.
- Start latency: EN sampled high at edge N -> CLKOUT=1, RISE=1 after edge N.
- Period in RUN: 2*(div_act+1) CLK cycles; duty exactly 50%.
- RISE/FALL: exactly one cycle, coincident with the first cycle of the new CLKOUT level; never both high.
- Divisor change latency: takes effect for the half-period beginning at the next toggle; a half-period in progress is never shortened or stretched.
- DIV_ACT updates on the same edge as the toggle that commits it.
- Stop latency: at most div_act+1 cycles (completing high phase) + 1.
- Reset mid-operation: outputs go to reset values immediately (asynchronous), regardless of phase.

## Test plan
- Reset then EN=1, DEFAULT_DIV=749: CLKOUT high 750 cycles, low 750, period 1500; RISE every 1500 cycles, FALL 750 after each RISE.
- IDLE, DIV_LD with DIV_IN=3, EN=1: CLKOUT pattern 4 high/4 low; DIV_ACT=3 immediately.
- RUN at div 9, DIV_LD DIV_IN=2 at cnt=4 of a high phase: high phase stays 10 cycles, subsequent half-periods 3 cycles; loads of 5 then 7 before boundary -> 7 applied.
- RUN at div 9, drop EN at cnt=2 of high phase: CLKOUT stays high 10 cycles total, FALL once, ACTIVE=0 next cycle; drop EN during low phase -> IDLE next edge, no FALL.
- DIV_IN=0: CLKOUT toggles every cycle, RISE/FALL alternate; STOP then EN=1 re-asserted in STOP -> RUN, no glitch, period unchanged.
- Assert RST mid-high-phase between edges: CLKOUT, RISE, FALL, ACTIVE=0 immediately; DIV_ACT=749 after release.
